// File: rtl/err_compute_pkg.sv
`default_nettype none
// ============================================================================
// Module      : err_compute_pkg
// Description : Shared types and sizes for the IR-sensor error generator.
// Revision    : 1.0 - initial release
// ============================================================================
package err_compute_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2
    } ec_state_t;

    localparam int NUM_CHNL = 8;
    localparam int ACC_W    = 17;
    localparam int ERR_W    = 11;
    localparam int CHNL_W   = $clog2(NUM_CHNL);

endpackage
`default_nettype wire

// File: rtl/err_compute_if.sv
`default_nettype none
// ============================================================================
// Module      : err_compute_if
// Description : Start/A2D/error-result bundle between err_compute and its peers.
// Revision    : 1.0 - initial release
// ============================================================================
interface err_compute_if #(
    parameter int SMPL_W = 12
);
    import err_compute_pkg::*;

    logic              start;
    logic              strt_cnv;
    logic [CHNL_W-1:0] chnl;
    logic              cnv_cmplt;
    logic [SMPL_W-1:0] smpl;
    logic              busy;
    logic [ERR_W-1:0]  err_sat;
    logic              err_vld;

    // master: requester and A2D side; slave: the error generator
    modport master (
        output start, cnv_cmplt, smpl,
        input  strt_cnv, chnl, busy, err_sat, err_vld
    );

    modport slave (
        input  start, cnv_cmplt, smpl,
        output strt_cnv, chnl, busy, err_sat, err_vld
    );

endinterface
`default_nettype wire

// File: rtl/err_compute_sat_signed.sv
`default_nettype none
// ============================================================================
// Module      : sat_signed
// Description : Combinational signed saturator, IN_W bits down to OUT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_signed #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 11
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    generate
        if (IN_W > OUT_W) begin : g_clamp
            logic [IN_W-OUT_W:0] w_top;
            logic                w_in_range;

            // representable iff the discarded bits are all copies of the result sign
            assign w_top      = i_din[IN_W-1:OUT_W-1];
            assign w_in_range = (&w_top) | ~(|w_top);
            assign o_dout     = w_in_range ? i_din[OUT_W-1:0]
                                           : {i_din[IN_W-1], {(OUT_W-1){~i_din[IN_W-1]}}};
        end else begin : g_extend
            assign o_dout = OUT_W'(i_din);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/err_compute.sv
`default_nettype none
// ============================================================================
// Module      : err_compute
// Description : Sequences eight A2D conversions, forms the weighted right-minus-
//               left sum, scales and saturates it into err_sat / err_vld.
// Revision    : 1.0 - initial release
// ============================================================================
module err_compute
    import err_compute_pkg::*;
#(
    parameter int SMPL_W    = 12,
    parameter int ERR_SHIFT = 3
) (
    input  logic         clk,
    input  logic         rst,
    err_compute_if.slave bus
);

    localparam logic [CHNL_W-1:0] c_LAST_CHNL = CHNL_W'(NUM_CHNL - 1);

    ec_state_t                r_state;
    ec_state_t                w_state_nxt;
    logic [CHNL_W-1:0]        r_chnl;
    logic signed [ACC_W-1:0]  r_accum;
    logic [ERR_W-1:0]         r_err_sat;
    logic                     r_err_vld;

    logic                     w_last;
    logic [ACC_W-1:0]         w_smpl_ext;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [ERR_W-1:0]  w_sat;

    assign w_last = (r_chnl == c_LAST_CHNL);

    // pair index is chnl>>1; odd channels are right sensors and add
    assign w_smpl_ext = {{(ACC_W-SMPL_W){1'b0}}, bus.smpl};
    assign w_term     = $signed(w_smpl_ext << r_chnl[CHNL_W-1:1]);
    assign w_acc_nxt  = r_chnl[0] ? (r_accum + w_term) : (r_accum - w_term);
    assign w_shifted  = w_acc_nxt >>> ERR_SHIFT;

    sat_signed #(
        .IN_W  (ACC_W),
        .OUT_W (ERR_W)
    ) u_sat (
        .i_din  (w_shifted),
        .o_dout (w_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = CONV;
            CONV:    w_state_nxt = WAIT;
            WAIT:    if (bus.cnv_cmplt) w_state_nxt = w_last ? IDLE : CONV;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.strt_cnv = (r_state == CONV);
        bus.busy     = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chnl    <= '0;
            r_accum   <= '0;
            r_err_sat <= '0;
            r_err_vld <= 1'b0;
        end else begin
            r_err_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_accum <= '0;
                        r_chnl  <= '0;
                    end
                end
                WAIT: begin
                    if (bus.cnv_cmplt) begin
                        r_accum <= w_acc_nxt;
                        if (w_last) begin
                            r_err_sat <= w_sat;
                            r_err_vld <= 1'b1;
                        end else begin
                            r_chnl <= r_chnl + CHNL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.chnl    = r_chnl;
    assign bus.err_sat = r_err_sat;
    assign bus.err_vld = r_err_vld;

endmodule
`default_nettype wire

// File: tb/tb_err_compute.sv
`default_nettype none
// ============================================================================
// Module      : tb_err_compute
// Description : Directed and random-latency bench for err_compute.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_err_compute;

    localparam int SMPL_W    = 12;
    localparam int ERR_SHIFT = 3;

    typedef logic [SMPL_W-1:0] vec_t [8];

    logic clk;
    logic rst;

    err_compute_if #(.SMPL_W(SMPL_W)) bus ();

    err_compute #(
        .SMPL_W    (SMPL_W),
        .ERR_SHIFT (ERR_SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_err    = 0;
    int          strt_cnt = 0;
    logic        m_busy   = 1'b0;
    logic        m_vld    = 1'b0;
    logic [10:0] m_sat    = 11'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: signed weighted sum, arithmetic shift, clamp to 11-bit signed
    function automatic logic [10:0] model(input vec_t s);
        int acc;
        int sh;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1) acc += int'(s[k]) * (1 << (k / 2));
            else            acc -= int'(s[k]) * (1 << (k / 2));
        end
        sh = acc >>> ERR_SHIFT;
        if (sh > 1023)       sh = 1023;
        else if (sh < -1024) sh = -1024;
        return sh[10:0];
    endfunction

    function automatic vec_t one_ch(input int ch, input logic [SMPL_W-1:0] v);
        vec_t r;
        foreach (r[i]) r[i] = '0;
        r[ch] = v;
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        foreach (r[i]) r[i] = SMPL_W'($urandom_range(0, 4095));
        return r;
    endfunction

    // every cycle: busy, err_vld and the held err_sat must match the model
    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("err_vld", 32'(bus.err_vld), 32'(m_vld));
        chk("err_sat", 32'(bus.err_sat), 32'(m_sat));
        if (bus.strt_cnv === 1'b1) strt_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            m_vld = 1'b0;
        end
    endtask

    task automatic reset_now(input string tag);
        #1 rst = 1'b1;
        m_busy = 1'b0;
        m_vld  = 1'b0;
        m_sat  = 11'h000;
        #1;
        chk({tag, " rst strt_cnv"}, 32'(bus.strt_cnv), 32'd0);
        chk({tag, " rst chnl"},     32'(bus.chnl),     32'd0);
        chk({tag, " rst busy"},     32'(bus.busy),     32'd0);
        chk({tag, " rst err_sat"},  32'(bus.err_sat),  32'd0);
        chk({tag, " rst err_vld"},  32'(bus.err_vld),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // one computation: start, then serve eight conversions; abort_after>0 resets mid-run
    task automatic run(input vec_t s, input int lat_max, input bit stray, input int abort_after,
                       input string tag, input bit chk_lit, input logic [10:0] lit);
        int lat;
        strt_cnt  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_vld     = 1'b0;
        m_busy    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 25 && bus.strt_cnv !== 1'b1; i++) tick();
            if (bus.strt_cnv !== 1'b1) begin
                chk({tag, " strt_cnv timeout"}, 32'd0, 32'd1);
                reset_now(tag);
                return;
            end
            chk({tag, " chnl"}, 32'(bus.chnl), 32'(k));
            tick();
            lat = (lat_max <= 1) ? 1 : $urandom_range(1, lat_max);
            repeat (lat - 1) begin
                bus.start = stray;
                tick();
                bus.start = 1'b0;
            end
            bus.start     = stray;
            bus.cnv_cmplt = 1'b1;
            bus.smpl      = s[k];
            tick();
            bus.cnv_cmplt = 1'b0;
            bus.start     = 1'b0;
            if (k + 1 == abort_after) begin
                reset_now(tag);
                return;
            end
        end
        m_vld  = 1'b1;
        m_sat  = model(s);
        m_busy = 1'b0;
        chk({tag, " strt_cnv cycles"}, 32'(strt_cnt), 32'd8);
        if (chk_lit) chk({tag, " literal"}, 32'(bus.err_sat), 32'(lit));
    endtask

    initial begin
        vec_t v;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cnv_cmplt = 1'b0;
        bus.smpl      = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (v[i]) v[i] = 12'h800;
        run(v, 1, 1'b0, 0, "all800", 1'b1, 11'h000);
        run(one_ch(1, 12'd800), 1, 1'b0, 0, "ch1_800_b2b", 1'b1, 11'h064);
        idle(1);
        run(one_ch(0, 12'd800), 1, 1'b0, 0, "ch0_800", 1'b1, 11'h79C);
        idle(2);
        run(one_ch(7, 12'd4095), 1, 1'b0, 0, "ch7_max", 1'b1, 11'h3FF);
        idle(1);
        run(one_ch(6, 12'd4095), 1, 1'b0, 0, "ch6_max", 1'b1, 11'h400);
        idle(1);
        run(one_ch(0, 12'd1), 1, 1'b0, 0, "floor_neg", 1'b1, 11'h7FF);
        idle(1);
        run(one_ch(7, 12'd1023), 1, 1'b0, 0, "edge_pos", 1'b1, 11'h3FF);
        idle(1);
        run(one_ch(6, 12'd1024), 1, 1'b0, 0, "edge_neg", 1'b1, 11'h400);
        idle(1);
        v    = one_ch(5, 12'd1000);
        v[2] = 12'd24;
        run(v, 1, 1'b0, 0, "mixed", 1'b1, 11'h1EE);

        // stray completions while idle must leave everything untouched
        tick();
        m_vld         = 1'b0;
        bus.cnv_cmplt = 1'b1;
        bus.smpl      = 12'hFFF;
        idle(3);
        bus.cnv_cmplt = 1'b0;
        idle(1);

        run(rand_vec(), 20, 1'b1, 0, "rand_stray_start", 1'b0, 11'h000);
        idle(2);
        run(rand_vec(), 20, 1'b0, 4, "abort", 1'b0, 11'h000);
        run(rand_vec(), 20, 1'b0, 0, "after_rst", 1'b0, 11'h000);
        idle(1);
        run(rand_vec(), 20, 1'b0, 0, "rand_a", 1'b0, 11'h000);
        run(rand_vec(), 20, 1'b0, 0, "rand_b", 1'b0, 11'h000);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
